// File: rtl/sysref_capture_ctrl_if.sv
// Control/status bundle between the AXI-lite register block, the DDC/DMA
// datapath and sysref_capture_ctrl.
interface sysref_capture_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             arm;
    logic             abort;
    logic [7:0]       sysref_skip;
    logic [CNT_W-1:0] capture_len;
    logic             data_valid;
    logic             nco_reset;
    logic             capture_en;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             arm_err;
    logic             timeout;
    logic [15:0]      sysref_count;

    modport master (
        output arm, abort, sysref_skip, capture_len, data_valid,
        input  nco_reset, capture_en, busy, done, aborted, arm_err, timeout, sysref_count
    );

    modport slave (
        input  arm, abort, sysref_skip, capture_len, data_valid,
        output nco_reset, capture_en, busy, done, aborted, arm_err, timeout, sysref_count
    );
endinterface

// File: rtl/sysref_capture_ctrl.sv
// SYSREF-aligned NCO phase reset and capture_len sample gating for the DDC capture path.
// Define SYSREF_CAPTURE_TIMEOUT_EN to build the WAIT_SR watchdog (TIMEOUT_W bits).
module sysref_capture_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sysref_in,
    sysref_capture_ctrl_if.slave ctrl
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SR,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    if (SYNC_STAGES < 2 || TIMEOUT_W < 1) begin : g_param_check
        $error("sysref_capture_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT_W >= 1");
    end

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sr_edge;
    logic                   qualify;
    logic [7:0]             skip_q, skip_d;
    logic [7:0]             edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       smp_cnt_q, smp_cnt_d;
    logic [15:0]            sr_cnt_q, sr_cnt_d;
    logic                   nco_reset;
    logic                   arm_err_q, arm_err_d;
    logic                   aborted_q, aborted_d;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic                   timeout_q, timeout_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sysref_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sr_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign qualify = sr_edge && (edge_cnt_q == skip_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            edge_cnt_q <= '0;
            len_q      <= '0;
            smp_cnt_q  <= '0;
            sr_cnt_q   <= '0;
            arm_err_q  <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            edge_cnt_q <= edge_cnt_d;
            len_q      <= len_d;
            smp_cnt_q  <= smp_cnt_d;
            sr_cnt_q   <= sr_cnt_d;
            arm_err_q  <= arm_err_d;
            aborted_q  <= aborted_d;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        edge_cnt_d = edge_cnt_q;
        len_d      = len_q;
        smp_cnt_d  = smp_cnt_q;
        sr_cnt_d   = sr_cnt_q + {15'd0, sr_edge};
        nco_reset  = 1'b0;
        arm_err_d  = 1'b0;
        aborted_d  = 1'b0;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
        timeout_d  = 1'b0;
        wd_d       = (state_q == ST_WAIT_SR) ? wd_q + 1'b1 : '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ctrl.arm && !ctrl.abort) begin
                    if (ctrl.capture_len != '0) begin
                        skip_d     = ctrl.sysref_skip;
                        len_d      = ctrl.capture_len;
                        edge_cnt_d = '0;
                        smp_cnt_d  = '0;
                        state_d    = ST_WAIT_SR;
                    end else begin
                        arm_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_SR: begin
                if (qualify) begin
                    nco_reset = 1'b1;
                    state_d   = ST_CAPTURE;
                end else begin
                    if (sr_edge) edge_cnt_d = edge_cnt_q + 8'd1;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
                    if (wd_q == '1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
`endif
                end
            end
            ST_CAPTURE: begin
                if (ctrl.data_valid) begin
                    if (smp_cnt_q == len_q - CNT_W'(1)) state_d = ST_DONE;
                    else                                smp_cnt_d = smp_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides whatever the active state decided, including a final sample or expiry.
        if (state_q != ST_IDLE) begin
            if (ctrl.abort) begin
                state_d   = ST_IDLE;
                nco_reset = 1'b0;
                aborted_d = 1'b1;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
            end else if (ctrl.arm) begin
                arm_err_d = 1'b1;
            end
        end
    end

    assign ctrl.nco_reset    = nco_reset;
    assign ctrl.capture_en   = (state_q == ST_CAPTURE);
    assign ctrl.busy         = (state_q != ST_IDLE);
    assign ctrl.done         = (state_q == ST_DONE);
    assign ctrl.aborted      = aborted_q;
    assign ctrl.arm_err      = arm_err_q;
    assign ctrl.sysref_count = sr_cnt_q;
`ifdef SYSREF_CAPTURE_TIMEOUT_EN
    assign ctrl.timeout      = timeout_q;
`else
    assign ctrl.timeout      = 1'b0;
`endif
endmodule
